// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver -- synchroniser, ps2_clk glitch filter and 11-bit frame deframer.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd-parity bit does not match the data byte.
module ps2_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_s;
  logic                   data_s;
  logic [FW-1:0]          filt_cnt_r;
  logic                   filt_r;
  logic                   filt_d_r;
  logic                   fall_s;

  logic [1:0]    state_r;
  logic [7:0]    shift_r;
  logic [2:0]    bit_cnt_r;
  logic          par_r;
  logic [TW-1:0] tmo_r;
  logic [7:0]    rx_data_r;
  logic          rx_done_r;
  logic          frame_err_r;
  logic          busy_r;

  logic [1:0]    state_nxt_s;
  logic [7:0]    shift_nxt_s;
  logic [2:0]    bit_cnt_nxt_s;
  logic          par_nxt_s;
  logic [TW-1:0] tmo_nxt_s;
  logic [7:0]    data_nxt_s;
  logic          done_nxt_s;
  logic          err_nxt_s;
  logic          parity_ok_s;
  logic          timeout_s;

  // Two-line synchroniser; idle-high reset so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];

  // Glitch filter: the filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_r <= {FW{1'b0}};
      filt_r     <= 1'b1;
      filt_d_r   <= 1'b1;
    end else begin
      filt_d_r <= filt_r;
      if (clk_s == filt_r) begin
        filt_cnt_r <= {FW{1'b0}};
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        filt_r     <= clk_s;
        filt_cnt_r <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign fall_s = filt_d_r & ~filt_r;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok_s = odd_parity_ok(shift_r, par_r);
`else
  // Parity bit is still captured, but never allowed to reject a frame.
  assign parity_ok_s = odd_parity_ok(shift_r, par_r) | 1'b1;
`endif

  // Abort fires TIMEOUT_CYCLES clocks after the edge that consumed the last fall event.
  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (tmo_r == TW'(TIMEOUT_CYCLES - 1));

  // Next-state logic for the deframer; only fall events and the timeout move the FSM.
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    par_nxt_s     = par_r;
    data_nxt_s    = rx_data_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;
    if ((state_r == ST_IDLE) || fall_s) begin
      tmo_nxt_s = {TW{1'b0}};
    end else begin
      tmo_nxt_s = tmo_r + TW'(1);
    end

    if (timeout_s) begin
      state_nxt_s = ST_IDLE;
      err_nxt_s   = 1'b1;
      tmo_nxt_s   = {TW{1'b0}};
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_s && rx_en) begin
            state_nxt_s   = ST_DATA;
            bit_cnt_nxt_s = 3'd0;
            shift_nxt_s   = 8'h00;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_nxt_s = {data_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_nxt_s = ST_PARITY;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          par_nxt_s   = data_s;
          state_nxt_s = ST_STOP;
        end
        ST_STOP: begin
          state_nxt_s = ST_IDLE;
          if (data_s && parity_ok_s) begin
            data_nxt_s = shift_r;
            done_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Deframer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      par_r       <= 1'b0;
      tmo_r       <= {TW{1'b0}};
      rx_data_r   <= 8'h00;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      par_r       <= par_nxt_s;
      tmo_r       <= tmo_nxt_s;
      rx_data_r   <= data_nxt_s;
      rx_done_r   <= done_nxt_s;
      frame_err_r <= err_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_done   = rx_done_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed self-checking bench for ps2_rx with hand-computed expected bytes and latencies.
module tb_ps2_rx;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 20000;
  // fall drive -> 2 sync edges -> 4 filter edges -> 1 FSM/output edge
  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  ps2_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_en    (rx_en),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #25 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, both_cnt = 0;
  int done_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (busy) busy_cnt = busy_cnt + 1;
    if (rx_done && frame_err) both_cnt = both_cnt + 1;
  end

  int checks = 0, errors = 0;
  int hp = 20;
  int fall_cyc = 0;
  int d0, e0, b0;

  task automatic check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(hp);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    tick(hp);
    ps2_clk  = 1'b1;
  endtask

  // nbits < 11 truncates the frame; drop_en clears rx_en right after the start bit
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b,
                            input int nbits, input logic drop_en);
    logic [10:0] bits;
    bits = {stop_b, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i]);
      if (i == 0 && drop_en) rx_en = 1'b0;
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_data;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rx_en    = 1'b1;

    // T1: reset held while the lines toggle
    tick(2);
    for (int i = 0; i < 8; i++) begin
      ps2_clk  = ~ps2_clk;
      ps2_data = i[0];
      tick(6);
    end
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_done", rx_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(10);
    rst_n = 1'b1;
    tick(50);
    check("post_rst_strobes", done_cnt + err_cnt + busy_cnt, 0);

    // T2: 0x1C at 12.5 kHz (80 us period = 1600 clk)
    hp = 800;
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    tick(5);
    check("t2_done_cnt", done_cnt - d0, 1);
    check("t2_err_cnt", err_cnt - e0, 0);
    check("t2_rx_data", rx_data, 8'h1C);
    check("t2_latency", done_cyc - fall_cyc, LAT);
    check("t2_busy", busy, 0);
    hp = 20;

    // T3: F0 then 1C back to back
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    check("t3_rx_data0", rx_data, 8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    check("t3_rx_data1", rx_data, 8'h1C);
    tick(5);
    check("t3_done_cnt", done_cnt - d0, 2);
    check("t3_err_cnt", err_cnt - e0, 0);

    // T4: bad parity, preceded by F0 so a held value is distinguishable
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    tick(5);
`ifdef PS2_PARITY_CHECK_EN
    check("t4_err_cnt", err_cnt - e0, 1);
    check("t4_done_cnt", done_cnt - d0, 0);
    check("t4_rx_data", rx_data, 8'hF0);
    exp_data = 8'hF0;
`else
    check("t4_err_cnt", err_cnt - e0, 0);
    check("t4_done_cnt", done_cnt - d0, 1);
    check("t4_rx_data", rx_data, 8'h1C);
    exp_data = 8'h1C;
`endif

    // T5a: stop bit 0
    snap();
    send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0);
    tick(5);
    check("t5_stop_err", err_cnt - e0, 1);
    check("t5_stop_done", done_cnt - d0, 0);
    check("t5_stop_data", rx_data, exp_data);
    check("t5_stop_busy", busy, 0);

    // T5b: clock stops after start + 4 data bits
    snap();
    send_frame(8'h0F, 1'b0, 1'b1, 5, 1'b0);
    check("t5_tmo_busy_mid", busy, 1);
    for (int i = 0; i < TIMEOUT_CYCLES + 200; i++) begin
      if (err_cnt != e0) break;
      tick(1);
    end
    check("t5_tmo_err", err_cnt - e0, 1);
    check("t5_tmo_time", err_cyc - fall_cyc, TIMEOUT_CYCLES + LAT);
    check("t5_tmo_done", done_cnt - d0, 0);
    check("t5_tmo_busy", busy, 0);
    check("t5_tmo_data", rx_data, exp_data);

    // recovery frame after the abort
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    tick(5);
    check("recover_done", done_cnt - d0, 1);
    check("recover_data", rx_data, 8'h5A);

    // T6a: 2-cycle low glitch in IDLE with data low
    snap();
    ps2_data = 1'b0;
    tick(hp);
    ps2_clk = 1'b0;
    tick(2);
    ps2_clk = 1'b1;
    tick(40);
    ps2_data = 1'b1;
    tick(10);
    check("t6_glitch_busy", busy_cnt - b0, 0);
    check("t6_glitch_strobes", (done_cnt - d0) + (err_cnt - e0), 0);

    // T6b: rx_en low at the start bit
    rx_en = 1'b0;
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    tick(5);
    check("t6_rxen_busy", busy_cnt - b0, 0);
    check("t6_rxen_strobes", (done_cnt - d0) + (err_cnt - e0), 0);
    check("t6_rxen_data", rx_data, 8'h5A);
    rx_en = 1'b1;

    // rx_en dropped mid-frame: frame still completes
    snap();
    send_frame(8'hA7, 1'b0, 1'b1, 11, 1'b1);
    tick(5);
    check("en_drop_done", done_cnt - d0, 1);
    check("en_drop_data", rx_data, 8'hA7);
    rx_en = 1'b1;

    // reset mid-frame discards the partial frame silently
    snap();
    send_frame(8'h3C, 1'b0, 1'b1, 4, 1'b0);
    rst_n = 1'b0;
    tick(2);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", rx_data, 8'h00);
    rst_n = 1'b1;
    tick(40);
    check("mid_rst_strobes", (done_cnt - d0) + (err_cnt - e0), 0);

    check("done_err_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
